// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one Gray<->binary converter across NREQ requesters.
// Optional macro GRAY_CONV_ARB_STATS_EN builds a saturating completed-transaction counter on done_cnt.
module gray_conv_arbiter #(
   parameter int  WIDTH = 4,
   parameter int  NREQ  = 4,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       req_mode,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       gnt,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  busy,
   output logic [7:0]            done_cnt
);

   typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

   state_t           state, state_nxt;
   logic [IDW-1:0]   ptr, win_idx, sel_idx;
   logic             win_mode;
   logic [WIDTH-1:0] win_data, conv_res, res_q;
   logic             handshake;

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   assign handshake = (state == RESP) && rsp_ready;

   // Scan from the top down so the lowest offset from ptr wins; NREQ is a power of two, so the sum wraps.
   always_comb begin
      sel_idx = ptr;
      for (int k = NREQ-1; k >= 0; k--) begin
         if (req[ptr + k[IDW-1:0]]) sel_idx = ptr + k[IDW-1:0];
      end
   end

   always_comb begin
      conv_res = '0;
      if (win_mode) conv_res = win_data ^ (win_data >> 1);
      else          conv_res = gray2bin(win_data);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|req) state_nxt = CONV;
         CONV:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         win_idx  <= '0;
         win_mode <= 1'b0;
         win_data <= '0;
         res_q    <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && |req) begin
            win_idx  <= sel_idx;
            win_mode <= req_mode[sel_idx];
            win_data <= req_data[sel_idx*WIDTH +: WIDTH];
         end
         if (state == CONV) res_q <= conv_res;
         if (handshake)     ptr   <= win_idx + 1'b1;
      end
   end

   always_comb begin
      gnt = '0;
      if (state == CONV) gnt[win_idx] = 1'b1;
   end

   // Response fields are forced to zero outside RESP so stale results never leak.
   assign rsp_valid = (state == RESP);
   assign rsp_id    = rsp_valid ? win_idx : '0;
   assign rsp_data  = rsp_valid ? res_q : '0;
   assign busy      = (state != IDLE);

`ifdef GRAY_CONV_ARB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                done_cnt <= '0;
      else if (handshake && done_cnt != 8'hFF) done_cnt <= done_cnt + 8'd1;
   end
`else
   assign done_cnt = 8'd0;
`endif

endmodule
